prog_loader_fetch: RTL and testbench
====================================

# prog_loader_fetch

Instruction-side front end of the 8-bit microprocessor: it sits directly upstream of the processor's `instruction` input and downstream of an external byte source. It accepts a program as a stream of 8-bit instruction bytes over a valid/ready handshake and stores them in on-chip instruction memory. It then releases the processor and returns the stored byte addressed by the processor's `pc` each cycle. A loader FSM sequences idle, load, run and error phases and tracks program length and overflow.

## Interface
- `DEPTH`, default 64: instruction memory words; power of two, 2..128.
- `NOP`, default 8'h00: byte driven on `instruction` when not running or when `pc` is outside the loaded program.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `load_start`  in  1  single-cycle request to begin a new program load.
- `load_valid`  in  1  source has a byte on `load_data`.
- `load_data`  in  8  instruction byte.
- `load_last`  in  1  qualifies the current beat as the final program byte.
- `load_ready`  out  1  block accepts a beat this cycle.
- `pc`  in  8  processor program counter.
- `instruction`  out  8  byte fetched for `pc`.
- `cpu_run`  out  1  high when the processor may execute; processor is held otherwise.
- `prog_len`  out  8  number of bytes in the current program.
- `load_err`  out  1  sticky overflow flag.

## Operation
- FSM states: IDLE, LOAD, RUN, ERR. Reset (async, `reset`=0) forces IDLE with `load_ready`=0, `cpu_run`=0, `prog_len`=0, `load_err`=0, write pointer=0, and `instruction`=NOP. Memory contents are not cleared.
- IDLE: `load_start`=1 -> LOAD. Entering LOAD clears the write pointer, `prog_len` and `load_err`.
- LOAD: `load_ready`=1. A beat transfers when `load_valid`&`load_ready`. It writes `load_data` to mem[ptr], then ptr+1.
  - Beat with `load_last`=1 -> RUN next cycle; `prog_len`=ptr+1.
  - Beat at ptr=DEPTH-1 with `load_last`=0: byte is stored, then -> ERR, `load_err`=1, `prog_len`=DEPTH.
  - Beat at ptr=DEPTH-1 with `load_last`=1 is a legal full program -> RUN, `prog_len`=DEPTH.
  - `load_start` is ignored in LOAD, including when it coincides with a beat; the beat is accepted normally.
- RUN: `cpu_run`=1, `load_ready`=0. `load_start`=1 -> LOAD (reload). Memory is overwritten from address 0, and bytes beyond the new length are stale but unreachable.
- ERR: `cpu_run`=0, `load_ready`=0, `load_err` held at 1. Only `load_start` -> LOAD exits; entering LOAD clears `load_err`.
- Fetch, combinational from `pc`:
  - `instruction` = mem[pc] when state=RUN and `pc` < `prog_len`.
  - Otherwise `instruction` = NOP. This includes `pc` >= DEPTH and `pc` at or beyond the end of the program.
  - Comparison is unsigned, 8-bit.
- `prog_len`=0 is never reached in RUN, because at least one beat is required.

## Timing
- Memory write is synchronous; a written byte is readable from the cycle after its write edge.
- `load_ready` rises the cycle after `load_start` is sampled in IDLE, RUN or ERR.
- `cpu_run` rises the cycle after the `load_last` beat is accepted. `instruction` for `pc`=0 is valid in that same cycle, so there are zero fetch cycles of latency.
- `cpu_run` falls the cycle after `load_start` is sampled in RUN; `instruction` reads NOP from that cycle.
- A reset assertion mid-load or mid-run takes effect immediately and asynchronously. After reset deasserts, the FSM stays in IDLE until the next `load_start`.
- `load_valid` while `load_ready`=0 is not a transfer; the source must hold the byte.

## Test plan
- Reset then load 3 bytes 8'h41, 8'h82, 8'hC3 (last on third) -> `cpu_run`=1 next cycle, `prog_len`=3. `pc`=0,1,2 gives 41, 82, C3; `pc`=3 and `pc`=200 give 00.
- Load with `load_valid` gaps between beats and `load_start` pulsed mid-load -> same 3-byte image, `prog_len`=3, no restart.
- Stream DEPTH=64 bytes without `load_last` -> ERR, `load_err`=1, `cpu_run`=0, `prog_len`=64, `load_ready`=0. Then `load_start` plus a 1-byte load of 8'h10 -> `load_err`=0, RUN, `pc`=0 gives 10.
- Exactly 64 bytes with `load_last` on the 64th -> RUN, `prog_len`=64, `pc`=63 gives the last byte, no error.
- In RUN with a 5-byte program, pulse `load_start` and load 2 bytes -> `cpu_run` low during the reload, then `prog_len`=2; `pc`=3 gives 00 despite the stale byte.
- Assert `reset`=0 during the second beat of a load -> outputs immediately at reset values. `load_start` is required to proceed; a beat presented before it is not accepted.

Source files
------------

// File: rtl/prog_loader_fetch.sv
// Instruction front end: loads a byte-stream program into local memory,
// then serves the processor's pc with zero-latency fetches.
module prog_loader_fetch #(
  parameter int         DEPTH = 64,
  parameter logic [7:0] NOP   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_run,
  output logic [7:0] prog_len,
  output logic       load_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [7:0]    LEN_FULL = 8'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_ptr;
  logic [7:0]      r_len;
  logic            r_err;
  logic [7:0]      r_mem [DEPTH];

  logic            w_beat;
  logic            w_enter;
  logic            w_at_end;
  logic [7:0]      w_ptr_len;
  logic            w_hit;

  assign w_beat    = load_valid & load_ready;
  assign w_enter   = load_start & (r_state != S_LOAD);
  assign w_at_end  = (r_ptr == PTR_LAST);
  assign w_ptr_len = {{(8-AW){1'b0}}, r_ptr} + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    cpu_run    = 1'b0;
    unique case (r_state)
      S_IDLE: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (load_last)     w_next = S_RUN;
          else if (w_at_end) w_next = S_ERR;
        end
      end
      S_RUN: begin
        cpu_run = 1'b1;
        if (load_start) w_next = S_LOAD;
      end
      S_ERR: if (load_start) w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (w_enter) begin
      r_ptr <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (w_beat) begin
      r_ptr <= r_ptr + 1'b1;
      if (load_last) begin
        r_len <= w_ptr_len;
      end else if (w_at_end) begin
        r_len <= LEN_FULL;
        r_err <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; stale bytes stay masked by prog_len.
  always_ff @(posedge clk) begin
    if (w_beat) r_mem[r_ptr] <= load_data;
  end

  assign w_hit       = (r_state == S_RUN) && (pc < r_len);
  assign instruction = w_hit ? r_mem[pc[AW-1:0]] : NOP;
  assign prog_len    = r_len;
  assign load_err    = r_err;

endmodule

// File: tb/tb_prog_loader_fetch.sv
// Directed bench for prog_loader_fetch: load, overflow, full image,
// reload and asynchronous reset scenarios.
module tb_prog_loader_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       cpu_run;
  logic [7:0] prog_len;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prog_loader_fetch #(.DEPTH(64), .NOP(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_run     (cpu_run),
    .prog_len    (prog_len),
    .load_err    (load_err)
  );

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last,
                           input logic st);
    int n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    load_start = st;
    while (!load_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout load_ready=%0b want 1", load_ready);
    end else begin
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_start = 0; load_valid = 0;
    load_data = 0; load_last = 0; pc = 0;
    #12;
    n_checks++;
    if ({load_ready, cpu_run, load_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 000",
               {load_ready, cpu_run, load_err});
    end
    n_checks++;
    if (prog_len !== 8'd0 || instruction !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_len_ins got %h/%h want 00/00",
               prog_len, instruction);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    logic [7:0] exp [5];
    exp[0] = 8'h41; exp[1] = 8'h82; exp[2] = 8'hC3;
    exp[3] = 8'h00; exp[4] = 8'h00;
    pulse_start();
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready got %b want 1", load_ready);
    end
    send_beat(8'h41, 0, 0);
    send_beat(8'h82, 0, 0);
    send_beat(8'hC3, 1, 0);
    n_checks++;
    if (cpu_run !== 1'b1 || prog_len !== 8'd3) begin
      n_fail++;
      $display("FAIL basic_run got run=%b len=%0d want 1/3",
               cpu_run, prog_len);
    end
    for (int i = 0; i < 5; i++) begin
      pc = (i == 4) ? 8'd200 : 8'(i);
      @(negedge clk);
      n_checks++;
      if (instruction !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_fetch pc=%0d got %h want %h",
                 pc, instruction, exp[i]);
      end
    end
  endtask

  task automatic test_full_image();
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_beat(8'hA0 ^ 8'(i), (i == 63), 0);
    n_checks++;
    if (cpu_run !== 1'b1 || prog_len !== 8'd64 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state got run=%b len=%0d err=%b want 1/64/0",
               cpu_run, prog_len, load_err);
    end
    pc = 8'd63;
    @(negedge clk);
    n_checks++;
    if (instruction !== 8'h9F) begin
      n_fail++;
      $display("FAIL full_pc63 got %h want 9f", instruction);
    end
    pc = 8'd64;
    @(negedge clk);
    n_checks++;
    if (instruction !== 8'h00) begin
      n_fail++;
      $display("FAIL full_pc64 got %h want 00", instruction);
    end
  endtask

  task automatic test_gaps_and_start();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h82; exp[2] = 8'hC3;
    @(posedge clk); #1;
    pulse_start();
    send_beat(8'h41, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(8'h82, 0, 1);
    n_checks++;
    if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_midload got rdy=%b run=%b want 1/0",
               load_ready, cpu_run);
    end
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    send_beat(8'hC3, 1, 0);
    n_checks++;
    if (cpu_run !== 1'b1 || prog_len !== 8'd3) begin
      n_fail++;
      $display("FAIL gap_run got run=%b len=%0d want 1/3",
               cpu_run, prog_len);
    end
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i);
      @(negedge clk);
      n_checks++;
      if (instruction !== exp[i]) begin
        n_fail++;
        $display("FAIL gap_fetch pc=%0d got %h want %h",
                 i, instruction, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_beat(8'(i + 8'h20), 0, 0);
    n_checks++;
    if ({load_err, cpu_run, load_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL ovf_flags got %b want 100",
               {load_err, cpu_run, load_ready});
    end
    n_checks++;
    if (prog_len !== 8'd64) begin
      n_fail++;
      $display("FAIL ovf_len got %0d want 64", prog_len);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (load_err !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_hold got err=%b rdy=%b want 1/0",
               load_err, load_ready);
    end
    pulse_start();
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b want 0", load_err);
    end
    send_beat(8'h10, 1, 0);
    pc = 8'd0;
    @(negedge clk);
    n_checks++;
    if (cpu_run !== 1'b1 || prog_len !== 8'd1 || instruction !== 8'h10) begin
      n_fail++;
      $display("FAIL ovf_recover got run=%b len=%0d ins=%h want 1/1/10",
               cpu_run, prog_len, instruction);
    end
  endtask

  task automatic test_reload();
    @(posedge clk); #1;
    pulse_start();
    send_beat(8'h11, 0, 0);
    send_beat(8'h22, 0, 0);
    send_beat(8'h33, 0, 0);
    send_beat(8'h44, 0, 0);
    send_beat(8'h55, 1, 0);
    pc = 8'd3;
    @(negedge clk);
    n_checks++;
    if (instruction !== 8'h44 || prog_len !== 8'd5) begin
      n_fail++;
      $display("FAIL reload_pre got ins=%h len=%0d want 44/5",
               instruction, prog_len);
    end
    @(posedge clk); #1;
    pc = 8'd0;
    pulse_start();
    n_checks++;
    if (cpu_run !== 1'b0 || instruction !== 8'h00) begin
      n_fail++;
      $display("FAIL reload_hold got run=%b ins=%h want 0/00",
               cpu_run, instruction);
    end
    send_beat(8'h66, 0, 0);
    n_checks++;
    if (cpu_run !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_mid got run=%b want 0", cpu_run);
    end
    send_beat(8'h77, 1, 0);
    pc = 8'd3;
    @(negedge clk);
    n_checks++;
    if (instruction !== 8'h00 || prog_len !== 8'd2) begin
      n_fail++;
      $display("FAIL reload_stale got ins=%h len=%0d want 00/2",
               instruction, prog_len);
    end
    pc = 8'd1;
    @(negedge clk);
    n_checks++;
    if (instruction !== 8'h77 || cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_new got ins=%h run=%b want 77/1",
               instruction, cpu_run);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    pc = 8'd0;
    pulse_start();
    send_beat(8'hA1, 0, 0);
    load_valid = 1'b1;
    load_data  = 8'hB2;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({load_ready, cpu_run, load_err} !== 3'b000 ||
        prog_len !== 8'd0 || instruction !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_now got %b len=%0d ins=%h want 000/0/00",
               {load_ready, cpu_run, load_err}, prog_len, instruction);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (load_ready !== 1'b0 || prog_len !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_idle got rdy=%b len=%0d want 0/0",
               load_ready, prog_len);
    end
    load_valid = 1'b0;
    pulse_start();
    send_beat(8'h5A, 1, 0);
    @(negedge clk);
    n_checks++;
    if (prog_len !== 8'd1 || instruction !== 8'h5A) begin
      n_fail++;
      $display("FAIL arst_resume got len=%0d ins=%h want 1/5a",
               prog_len, instruction);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_full_image();
    test_gaps_and_start();
    test_overflow();
    test_reload();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
